// File: rtl/phase_pkg.sv
// Shared constants for the phase-centering datapath: default widths,
// fix16_13 pi values and the software control word layout.
package phase_pkg;
    localparam int PHASE_W_DEF     = 16;
    localparam int N_CHAN_BITS_DEF = 8;
    localparam int PI_FIX          = 25736;
    localparam int TWO_PI_FIX      = 51472;
    localparam int CTRL_TOG_BIT    = 31;
    localparam int CTRL_BYP_BIT    = 30;
    localparam int CTRL_CHAN_LSB   = 16;
    localparam int CTRL_CENTER_LSB = 0;
endpackage

// File: rtl/center_ram.sv
// Per-channel center table: simple dual-port, read-first, registered read.
module center_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    // Zero contents come from configuration only; reset never touches the table.
    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/phase_center_sub.sv
// Subtracts a per-channel center from each phase sample and wraps the
// result into [-pi, pi]; three-stage pipeline, one sample per cycle.
module phase_center_sub #(
    parameter int N_CHAN_BITS = phase_pkg::N_CHAN_BITS_DEF,
    parameter int PHASE_W     = phase_pkg::PHASE_W_DEF,
    parameter int PI_FIX      = phase_pkg::PI_FIX
) (
    input  logic                   user_clk,
    input  logic                   user_rst,
    input  logic [31:0]            ctrl_word,
    input  logic                   in_valid,
    input  logic [N_CHAN_BITS-1:0] in_chan,
    input  logic [PHASE_W-1:0]     in_phase,
    output logic                   out_valid,
    output logic [N_CHAN_BITS-1:0] out_chan,
    output logic [PHASE_W-1:0]     out_phase,
    output logic [15:0]            wr_count
);
    import phase_pkg::*;

    localparam int DW     = PHASE_W + 1;
    localparam int WW     = PHASE_W + 2;
    localparam int TWO_PI = (PI_FIX == phase_pkg::PI_FIX) ? TWO_PI_FIX : 2 * PI_FIX;

    function automatic logic signed [PHASE_W-1:0] wrap_phase(input logic signed [DW-1:0] d);
        logic signed [WW-1:0] x;
        x = WW'(d);
        if (x > WW'(PI_FIX)) begin
            x = x - WW'(TWO_PI);
        end else if (x < -WW'(PI_FIX)) begin
            x = x + WW'(TWO_PI);
        end
        return x[PHASE_W-1:0];
    endfunction

    logic                          tog_hist_q, tog_hist_d;
    logic                          wr_en;
    logic [15:0]                   wr_count_q, wr_count_d;
    logic                          vld_p1_q, vld_p1_d;
    logic [N_CHAN_BITS-1:0]        chan_p1_q, chan_p1_d;
    logic signed [PHASE_W-1:0]     phase_p1_q, phase_p1_d;
    logic signed [PHASE_W-1:0]     center_p1;
    logic                          vld_p2_q, vld_p2_d;
    logic [N_CHAN_BITS-1:0]        chan_p2_q, chan_p2_d;
    logic signed [DW-1:0]          diff_p2_q, diff_p2_d;
    logic                          byp_p2_q, byp_p2_d;
    logic                          out_valid_q, out_valid_d;
    logic [N_CHAN_BITS-1:0]        out_chan_q, out_chan_d;
    logic [PHASE_W-1:0]            out_phase_q, out_phase_d;
    logic                          unused_ctrl;

    assign unused_ctrl = ^ctrl_word[29:24];

    // Stage 1: table read happens inside the RAM, registered alongside the sample.
    center_ram #(
        .ADDR_W(N_CHAN_BITS),
        .DATA_W(PHASE_W)
    ) u_center_ram (
        .clk    (user_clk),
        .wr_en  (wr_en),
        .wr_addr(ctrl_word[CTRL_CHAN_LSB +: N_CHAN_BITS]),
        .wr_data(ctrl_word[CTRL_CENTER_LSB +: PHASE_W]),
        .rd_addr(in_chan),
        .rd_data(center_p1)
    );

    always_comb begin
        tog_hist_d  = ctrl_word[CTRL_TOG_BIT];
        wr_en       = ctrl_word[CTRL_TOG_BIT] & ~tog_hist_q & ~user_rst;
        wr_count_d  = wr_en ? wr_count_q + 16'd1 : wr_count_q;

        vld_p1_d    = in_valid;
        chan_p1_d   = in_chan;
        phase_p1_d  = in_phase;

        // Stage 2: full-width difference, bypass sampled here.
        vld_p2_d    = vld_p1_q;
        chan_p2_d   = chan_p1_q;
        byp_p2_d    = ctrl_word[CTRL_BYP_BIT];
        diff_p2_d   = byp_p2_d ? DW'(phase_p1_q) : DW'(phase_p1_q) - DW'(center_p1);

        // Stage 3: wrap into [-pi, pi]; outputs hold while idle.
        out_valid_d = vld_p2_q;
        out_chan_d  = out_chan_q;
        out_phase_d = out_phase_q;
        if (vld_p2_q) begin
            out_chan_d  = chan_p2_q;
            out_phase_d = byp_p2_q ? diff_p2_q[PHASE_W-1:0] : wrap_phase(diff_p2_q);
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            tog_hist_q  <= 1'b1;
            wr_count_q  <= '0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_phase_q <= '0;
        end else begin
            tog_hist_q  <= tog_hist_d;
            wr_count_q  <= wr_count_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_phase_q <= out_phase_d;
        end
    end

    always_ff @(posedge user_clk) begin
        chan_p1_q  <= chan_p1_d;
        phase_p1_q <= phase_p1_d;
        chan_p2_q  <= chan_p2_d;
        diff_p2_q  <= diff_p2_d;
        byp_p2_q   <= byp_p2_d;
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_phase = out_phase_q;
    assign wr_count  = wr_count_q;
endmodule

// File: tb/tb_phase_center_sub.sv
// Directed bench for phase_center_sub with a cycle-level reference model.
module tb_phase_center_sub;
    logic               clk = 1'b0;
    logic               user_rst;
    logic [31:0]        ctrl_word;
    logic               in_valid;
    logic [7:0]         in_chan;
    logic signed [15:0] in_phase;
    logic               out_valid;
    logic [7:0]         out_chan;
    logic [15:0]        out_phase;
    logic [15:0]        wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    phase_center_sub dut (
        .user_clk (clk),
        .user_rst (user_rst),
        .ctrl_word(ctrl_word),
        .in_valid (in_valid),
        .in_chan  (in_chan),
        .in_phase (in_phase),
        .out_valid(out_valid),
        .out_chan (out_chan),
        .out_phase(out_phase),
        .wr_count (wr_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table of centers, pending samples with their due edge.
    typedef struct {
        int chan;
        int phase;
        int center;
        bit byp;
        int due;
    } item_t;

    int    tab [256];
    item_t q [$];
    int    m_valid = 0, m_chan = 0, m_phase = 0, m_cnt = 0;
    bit    m_hist = 1'b1;
    bit    m_live = 1'b0;
    int    cyc = 0;

    function automatic int wrap_ref(input int d);
        if (d > 25736) return d - 51472;
        if (d < -25736) return d + 51472;
        return d;
    endfunction

    initial begin
        foreach (tab[i]) tab[i] = 0;
    end

    initial forever begin
        item_t it;
        @(posedge clk);
        cyc++;
        if (user_rst) begin
            q.delete();
            m_valid = 0;
            m_chan  = 0;
            m_phase = 0;
            m_cnt   = 0;
            m_hist  = 1'b1;
            m_live  = 1'b1;
        end else begin
            m_valid = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                it      = q.pop_front();
                m_valid = 1;
                m_chan  = it.chan;
                m_phase = it.byp ? it.phase : wrap_ref(it.phase - it.center);
            end
            foreach (q[i]) if (q[i].due == cyc + 1) q[i].byp = ctrl_word[30];
            if (in_valid)
                q.push_back('{chan: int'(in_chan), phase: int'(in_phase),
                              center: tab[in_chan], byp: 1'b0, due: cyc + 2});
            if (ctrl_word[31] && !m_hist) begin
                tab[ctrl_word[23:16]] = int'($signed(ctrl_word[15:0]));
                m_cnt = (m_cnt + 1) % 65536;
            end
            m_hist = ctrl_word[31];
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("out_valid", int'(out_valid), m_valid);
            chk("out_chan", int'(out_chan), m_chan);
            chk("out_phase", int'($signed(out_phase)), m_phase);
            chk("wr_count", int'(wr_count), m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input bit tog, input bit byp, input int chan, input int center);
        ctrl_word = {tog, byp, 6'd0, 8'(chan), 16'(center)};
    endtask

    task automatic do_write(input int chan, input int center);
        set_ctrl(1'b0, ctrl_word[30], chan, center);
        tick();
        set_ctrl(1'b1, ctrl_word[30], chan, center);
        tick();
    endtask

    task automatic send(input string name, input int chan, input int phase, input int exp);
        in_valid = 1'b1;
        in_chan  = 8'(chan);
        in_phase = 16'(phase);
        tick();
        in_valid = 1'b0;
        tick();
        chk({name, "_early"}, int'(out_valid), 0);
        tick();
        chk({name, "_vld"}, int'(out_valid), 1);
        chk({name, "_chan"}, int'(out_chan), chan);
        chk({name, "_phase"}, int'($signed(out_phase)), exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        user_rst = 1'b1;
        ctrl_word = '0;
        in_valid = 1'b0;
        in_chan = '0;
        in_phase = '0;
        repeat (3) tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_chan", int'(out_chan), 0);
        chk("rst_phase", int'(out_phase), 0);
        chk("rst_wr_count", int'(wr_count), 0);
        user_rst = 1'b0;
        tick();

        do_write(5, 1000);
        chk("t1_wr_count", int'(wr_count), 1);
        send("t1", 5, 3000, 2000);

        do_write(7, -10000);
        send("wrap_pos", 7, 20000, -21472);
        do_write(8, 10000);
        send("wrap_neg", 8, -20000, 21472);
        chk("t2_wr_count", int'(wr_count), 3);

        send("edge_pi", 0, 25736, 25736);
        send("edge_mpi", 0, -25736, -25736);
        send("edge_pi1", 0, 25737, -25735);
        do_write(10, -32768);
        send("max_diff", 10, 32767, 14063);
        do_write(11, 32767);
        send("min_diff", 11, -32768, -14063);

        set_ctrl(1'b0, 1'b0, 3, 500);
        tick();
        set_ctrl(1'b1, 1'b0, 3, 500);
        in_valid = 1'b1;
        in_chan  = 8'd3;
        in_phase = 16'sd800;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("rf_old_vld", int'(out_valid), 1);
        chk("rf_old_phase", int'($signed(out_phase)), 800);
        chk("rf_wr_count", int'(wr_count), 6);
        send("rf_new", 3, 800, 300);
        set_ctrl(1'b0, 1'b0, 3, 777);
        tick();
        tick();
        chk("fall_wr_count", int'(wr_count), 6);
        send("fall_kept", 3, 800, 300);

        set_ctrl(1'b0, 1'b1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_chan  = 8'(i);
            in_phase = 16'(100 * (i + 1));
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("byp_vld", int'(out_valid), 1);
            chk("byp_chan", int'(out_chan), i);
            chk("byp_phase", int'($signed(out_phase)), 100 * (i + 1));
            tick();
        end
        chk("byp_idle", int'(out_valid), 0);
        send("byp_nowrap", 5, 30000, 30000);
        set_ctrl(1'b0, 1'b0, 0, 0);
        tick();

        in_valid = 1'b1;
        in_chan  = 8'd5;
        in_phase = 16'sd3000;
        tick();
        in_chan  = 8'd7;
        in_phase = 16'sd0;
        tick();
        in_valid = 1'b0;
        user_rst = 1'b1;
        set_ctrl(1'b1, 1'b0, 9, 1234);
        tick();
        chk("flush_vld0", int'(out_valid), 0);
        tick();
        chk("flush_vld1", int'(out_valid), 0);
        user_rst = 1'b0;
        repeat (3) tick();
        chk("flush_vld2", int'(out_valid), 0);
        chk("flush_chan", int'(out_chan), 0);
        chk("flush_phase", int'(out_phase), 0);
        chk("held_wr_count", int'(wr_count), 0);
        send("no_edge", 9, 1234, 1234);
        send("kept5", 5, 3000, 2000);
        send("kept7", 7, 20000, -21472);
        set_ctrl(1'b0, 1'b0, 9, 1234);
        tick();
        set_ctrl(1'b1, 1'b0, 9, 1234);
        tick();
        chk("post_edge_wr_count", int'(wr_count), 1);
        send("post_edge", 9, 1234, 0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/phase_center_sub.md
PHASE_CENTER_SUB -- requirements
Module: phase_center_sub

Interface
REQ-001 SHALL have parameter N_CHAN_BITS, default 8, channel index width (256 channels).
REQ-002 SHALL have parameter PHASE_W, default 16, phase sample width, signed fix16_13 radians.
REQ-003 SHALL have parameter PI_FIX, default 25736, pi in fix16_13.
REQ-004 SHALL have port user_clk  in  1  sole clock for all logic.
REQ-005 SHALL have port user_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port ctrl_word  in  32  software register word: [31] write toggle, [30] bypass, [23:16] channel, [15:0] signed center.
REQ-007 SHALL have port in_valid  in  1  input sample qualifier.
REQ-008 SHALL have port in_chan  in  N_CHAN_BITS  channel of input sample.
REQ-009 SHALL have port in_phase  in  PHASE_W  signed input phase.
REQ-010 SHALL have port out_valid  out  1  output sample qualifier.
REQ-011 SHALL have port out_chan  out  N_CHAN_BITS  channel of output sample.
REQ-012 SHALL have port out_phase  out  PHASE_W  centered, wrapped phase.
REQ-013 SHALL have port wr_count  out  16  number of center-table writes since reset.

Function
REQ-014 SHALL hold a 2^N_CHAN_BITS x PHASE_W center table, read-first, one write port and one read port.
REQ-015 SHALL write ctrl_word[15:0] into the table entry ctrl_word[23:16] in the cycle after a 0->1 transition of ctrl_word[31].
REQ-016 SHALL ignore level, 1->0 transitions and a ctrl_word[31] already high at reset release.
REQ-017 SHALL increment wr_count once per table write, wrapping 65535->0.
REQ-018 SHALL use a fixed 3-cycle latency: stage 1 table read, stage 2 subtract, stage 3 wrap; out_valid/out_chan follow in_valid/in_chan by exactly 3 cycles.
REQ-019 SHALL compute diff = in_phase - center as a 17-bit signed value, no truncation before the wrap.
REQ-020 SHALL output diff - 2*PI_FIX if diff > PI_FIX, diff + 2*PI_FIX if diff < -PI_FIX, else diff; the result fits PHASE_W.
REQ-021 SHALL, when ctrl_word[30]=1 (sampled at stage 2), output in_phase unchanged with the same 3-cycle latency.
REQ-022 SHALL, on a table write and a read of the same channel in the same cycle, return the old center to the read.
REQ-023 SHALL accept a new sample every cycle; no back-pressure.
REQ-024 SHALL leave out_phase/out_chan unspecified-but-stable when out_valid=0 (hold last value).

Reset
REQ-025 SHALL clear out_valid, out_chan, out_phase, wr_count and all pipeline valid bits to 0 on user_rst.
REQ-026 SHALL set the toggle-edge history bit to 1 on user_rst.
REQ-027 SHALL not clear the center table on reset; table initialises to all zeros at configuration only.
REQ-028 SHALL discard samples in flight when user_rst asserts mid-stream; no out_valid for them afterwards.

Structure
REQ-029 SHALL place PHASE_W, N_CHAN_BITS defaults, PI_FIX, TWO_PI_FIX (51472) and the ctrl_word bit-field positions in a shared package phase_pkg.
REQ-030 SHALL implement the table as sub-module center_ram (simple dual-port, read-first, 1-cycle registered read).

Verification
REQ-031 SHALL test: toggle bit 31 with chan 5, center 1000, then sample chan 5 phase 3000 -> 3 cycles later out_phase 2000, out_chan 5, wr_count 1.
REQ-032 SHALL test: center -10000 on chan 7, phase 20000 -> out_phase -21472; center 10000 on chan 8, phase -20000 -> out_phase 21472.
REQ-033 SHALL test: bit 31 held high through and after reset release -> no write, wr_count 0; subsequent 0->1 -> wr_count 1.
REQ-034 SHALL test: write center 500 to chan 3 in same cycle as a read of chan 3 (old center 0), phase 800 -> out 800; next sample phase 800 -> out 300.
REQ-035 SHALL test: bypass=1, back-to-back samples phases 100,200,300 on chans 0,1,2 -> identical values out on 3 consecutive cycles, latency 3.
REQ-036 SHALL test: user_rst asserted with 2 samples in flight -> out_valid stays 0, outputs 0, table contents preserved.
